mmio_button_hub: RTL and testbench
==================================

# mmio_button_hub

Parametrised memory-mapped button/LED hub for the Sly-Man-Says processor wrapper. Replaces the fixed four-button poll and single LED flash with N debounced buttons, a press-event FIFO the processor drains with `lw`, a status/control word, and per-LED on/off/timed-flash control driven by `sw`. It sits beside the RAM on the data-memory bus; the wrapper muxes `dataOut` into `q_dmem` whenever `hit` is high.

## Interface
- `NUM_BUTTONS`, 4: buttons and LEDs, legal range 2..16.
- `DEBOUNCE_CYCLES`, 500000: number of consecutive stable cycles a raw level needs before it is accepted, at least 1.
- `FIFO_DEPTH`, 8: event FIFO entries, a power of two, at least 2.
- `FLASH_CYCLES`, 25000000: on-time of a timed flash, at least 1.
- `ADDR_EVENT`, 12'd7: event pop address.
- `ADDR_STATUS`, 12'd9: status read / control write address.
- `ADDR_LED`, 12'd6: LED command address.

Ports:
- `clock` input, 1 bit: the single clock (50 MHz). All state changes on its rising edge.
- `reset` input, 1 bit: asynchronous, active-high.
- `buttons` input, NUM_BUTTONS bits: raw, asynchronous, active-high button levels.
- `addr` input, 12 bits: data-memory address.
- `wEn` input, 1 bit: store strobe.
- `rEn` input, 1 bit: one-cycle load strobe from the memory stage.
- `dataIn` input, 32 bits: store data.
- `dataOut` output, 32 bits: read data, combinational from `addr`.
- `hit` output, 1 bit: combinational; high when `addr` is ADDR_EVENT or ADDR_STATUS.
- `leds` output, NUM_BUTTONS bits: LED drive, active-high.

## Operation
**Input conditioning (per button)**
- Each button passes through a 2-flop synchroniser, then a debounce counter.
- The counter clears whenever the synchronised level equals the debounced level.
- Otherwise the counter increments. When it reaches DEBOUNCE_CYCLES, the debounced level takes the synchronised value and the counter clears.
- A debounced 0→1 transition sets that button's `pending` bit. Releases generate no event.

**Enqueue arbitration**
- Each cycle, the lowest-index set `pending` bit is pushed into the FIFO and cleared.
- At most one push per cycle. Simultaneous presses are enqueued in ascending index order on consecutive cycles.
- If the FIFO is full and no pop happens that cycle, the event is dropped, its pending bit is cleared, and sticky `overflow` is set.
- A pending bit set while its previous press is still pending stays set, so duplicate presses merge.

**Event word** (`addr`==ADDR_EVENT):
- bit31 = FIFO non-empty.
- bit30 = `overflow`.
- bits[3:0] = head button index.
- All other bits are 0. When the FIFO is empty, the word is 0 except bit30.

**Pop**
- On `rEn` with `addr`==ADDR_EVENT and the FIFO non-empty, the head is removed at that edge.
- A pop of an empty FIFO is a no-op.
- Push and pop in the same cycle are both honoured, including when the FIFO is full; count is unchanged.

**Status word** (`addr`==ADDR_STATUS):
- bits[15:0] = debounced levels, zero-extended.
- bits[23:16] = FIFO count.
- bit30 = `overflow`.
- All other bits are 0.

**Control write** (`wEn`, ADDR_STATUS):
- `dataIn[0]`=1 flushes the FIFO, clears all pending bits and clears `overflow`.
- A flush beats a same-cycle push or pop.
- `dataIn[0]`=0 has no effect.

**LED command** (`wEn`, ADDR_LED):
- `dataIn[3:0]` = index.
- `dataIn[4]` = on/off.
- `dataIn[5]` = timed.
- If timed=0: the LED is set to on/off and its flash timer is cancelled.
- If timed=1 and on/off=1: the LED turns on and its timer loads FLASH_CYCLES. It turns off when the timer reaches 0, decrementing once per cycle.
- If timed=1 and on/off=0: behaves as plain off.
- Indices ≥ NUM_BUTTONS are ignored.
- A new command to the same LED restarts or overrides any running flash.
- LEDs are independent.

**Bus behaviour**
- `wEn` to ADDR_EVENT is ignored.
- `rEn` to any address other than ADDR_EVENT has no side effect.

## Timing
- **Reset values:** synchronisers, debounced levels, counters, pending bits, FIFO pointers and count, `overflow`, LED state and flash timers are all 0. `leds`=0. `dataOut` for ADDR_EVENT reads 0.
- **Reset mid-operation:** reset asserted mid-debounce, mid-flash, or with a non-empty FIFO returns everything to the reset values immediately, without waiting for a clock edge.
- **Isolated press latency (D = DEBOUNCE_CYCLES, FIFO empty):**
  - Raw level sampled at edge 0.
  - Synchronised at edge 2.
  - Debounced at edge D+2.
  - Pending bit set at edge D+3.
  - Pushed at edge D+4; `dataOut[31]` at ADDR_EVENT is 1 after edge D+4.
- **Glitch rejection:** a raw pulse or bounce shorter than D stable synchronised cycles produces no event.
- **Pop:** the next head is visible on `dataOut` immediately after the popping edge.
- **LED command:** `leds` changes at the edge that samples `wEn`. A timed flash keeps the LED high for exactly FLASH_CYCLES cycles.

## Test plan
1. **Clean press, D=4, depth 8.** Press button 2 cleanly and hold. Required: ADDR_EVENT reads 0x80000002 after edge 8, status bits[23:16] read 1, and an `rEn` pop makes ADDR_EVENT read 0.
2. **Bounce rejection.** Toggle button 1 every 2 cycles for 20 cycles, then hold high. Required: exactly one event (index 1), timed D+4 edges after the final rise settles.
3. **Simultaneous presses.** Press buttons 3, 0 and 1 on the same edge. Required: three pops return indices 0, 1, 3 in that order, then the FIFO is empty.
4. **Overflow and flush, depth 4.** Produce 5 presses with no pops. Required: count 4, bit30 set, fifth event lost, and the first pop returns the first press. Then write 1 to ADDR_STATUS. Required: count 0, bit30 clear.
5. **LED commands.** Write 0x32 (index 2, on, timed) with FLASH_CYCLES=10. Required: `leds[2]` is high for exactly 10 cycles. Write 0x11, then 0x01. Required: `leds[1]` goes on, then off. Write index 7 with 4 LEDs. Required: no change.
6. **Reset mid-operation.** Assert reset with 3 events queued and a flash running. Required: `leds`=0 without waiting for a clock edge, and status reads 0 after reset is released.

Source files
------------

// File: rtl/mmio_button_hub.sv
// mmio_button_hub: memory-mapped hub for N debounced push buttons and N LEDs.
// Each button is synchronised and debounced. Every debounced press queues its
// index in an event FIFO, which the processor drains with loads. A status word
// reports the current levels and the FIFO state, and a store to the same address
// can flush the queue. Each LED is driven on or off directly, or lit for a fixed
// timed flash.
//
// Bus handshake: there is no stall. dataOut and hit depend combinationally on
// addr alone. A load side effect (an event pop) takes place at the rising edge
// where rEn is high. A store takes effect at the rising edge where wEn is high.
module mmio_button_hub #(
    parameter int          NUM_BUTTONS     = 4,
    parameter int          DEBOUNCE_CYCLES = 500000,
    parameter int          FIFO_DEPTH      = 8,
    parameter int          FLASH_CYCLES    = 25000000,
    parameter logic [11:0] ADDR_EVENT      = 12'd7,
    parameter logic [11:0] ADDR_STATUS     = 12'd9,
    parameter logic [11:0] ADDR_LED        = 12'd6
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NUM_BUTTONS-1:0] buttons,
    input  logic [11:0]            addr,
    input  logic                   wEn,
    input  logic                   rEn,
    input  logic [31:0]            dataIn,
    output logic [31:0]            dataOut,
    output logic                   hit,
    output logic [NUM_BUTTONS-1:0] leds
);

    // Widths. The debounce counter has to hold DEBOUNCE_CYCLES itself. The FIFO
    // count has to hold FIFO_DEPTH. The flash timer has to hold FLASH_CYCLES.
    localparam int CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int COUNT_W = PTR_W + 1;
    localparam int TMR_W   = $clog2(FLASH_CYCLES + 1);

    localparam logic [CNT_W-1:0]   DB_LIMIT   = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [COUNT_W-1:0] FIFO_FULL  = COUNT_W'(FIFO_DEPTH);
    localparam logic [TMR_W-1:0]   FLASH_LOAD = TMR_W'(FLASH_CYCLES);

    // ------------------------------------------------------------------
    // Input conditioning state
    // ------------------------------------------------------------------
    logic [NUM_BUTTONS-1:0]            sync1_q, sync2_q;
    logic [NUM_BUTTONS-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [NUM_BUTTONS-1:0]            deb_q, deb_d;
    logic [NUM_BUTTONS-1:0]            deb_prev_q;
    logic [NUM_BUTTONS-1:0]            pending_q, pending_d;
    logic [NUM_BUTTONS-1:0]            rise;

    // ------------------------------------------------------------------
    // Event FIFO state
    // ------------------------------------------------------------------
    logic [FIFO_DEPTH-1:0][3:0] mem_q;
    logic [PTR_W-1:0]           wr_ptr_q, rd_ptr_q;
    logic [COUNT_W-1:0]         count_q, count_d;
    logic                       overflow_q, overflow_d;

    // ------------------------------------------------------------------
    // LED state
    // ------------------------------------------------------------------
    logic [NUM_BUTTONS-1:0]            led_q, led_d;
    logic [NUM_BUTTONS-1:0][TMR_W-1:0] tmr_q, tmr_d;

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    logic       sel_event, sel_status, sel_led;
    logic       flush, pop, push, push_req, drop;
    logic       fifo_empty, fifo_full;
    logic [3:0] push_idx;
    logic [NUM_BUTTONS-1:0] push_onehot;
    logic [3:0] cmd_idx;
    logic       cmd_on, cmd_timed, cmd_hit;
    logic       unused_data;

    assign sel_event  = (addr == ADDR_EVENT);
    assign sel_status = (addr == ADDR_STATUS);
    assign sel_led    = (addr == ADDR_LED);
    assign hit        = sel_event || sel_status;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == FIFO_FULL);

    // A flush takes priority over a push or a pop in the same cycle.
    assign flush = wEn && sel_status && dataIn[0];
    assign pop   = rEn && sel_event && !fifo_empty;

    assign cmd_hit   = wEn && sel_led;
    assign cmd_idx   = dataIn[3:0];
    assign cmd_on    = dataIn[4];
    assign cmd_timed = dataIn[5];
    assign unused_data = ^dataIn[31:6];

    // A one-cycle pulse marks a debounced press. A release produces no pulse.
    assign rise = deb_q & ~deb_prev_q;

    // Debounce: count consecutive cycles where the synchronised level differs
    // from the accepted level, and accept the new level once the count has
    // reached the limit.
    always_comb begin
        deb_d = deb_q;
        cnt_d = cnt_q;
        for (int i = 0; i < NUM_BUTTONS; i++) begin
            if (sync2_q[i] == deb_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == DB_LIMIT) begin
                deb_d[i] = sync2_q[i];
                cnt_d[i] = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    // Arbitration: the lowest-index pending button wins the single push slot.
    always_comb begin
        push_idx = '0;
        for (int i = NUM_BUTTONS - 1; i >= 0; i--) begin
            if (pending_q[i]) push_idx = 4'(i);
        end
    end

    assign push_req    = |pending_q;
    assign push_onehot = pending_q & (~pending_q + NUM_BUTTONS'(1));
    // A full FIFO still accepts a push when a pop frees a slot at the same edge.
    assign push        = push_req && (!fifo_full || pop);
    assign drop        = push_req && fifo_full && !pop;

    // Pending bits: the winner is cleared, whether it was pushed or dropped. A new
    // press for a button that is still pending merges with the existing one.
    always_comb begin
        pending_d = (pending_q & ~push_onehot) | rise;
        if (flush) pending_d = '0;
    end

    // FIFO occupancy and the sticky overflow flag.
    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + COUNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - COUNT_W'(1);
        end
        overflow_d = overflow_q | drop;
        if (flush) begin
            count_d    = '0;
            overflow_d = 1'b0;
        end
    end

    // LED next state. A running timer counts down and turns the LED off when it
    // expires. A command addressed to the LED overrides whatever was running.
    always_comb begin
        led_d = led_q;
        tmr_d = tmr_q;
        for (int i = 0; i < NUM_BUTTONS; i++) begin
            if (tmr_q[i] != '0) begin
                tmr_d[i] = tmr_q[i] - TMR_W'(1);
                if (tmr_q[i] == TMR_W'(1)) led_d[i] = 1'b0;
            end
            if (cmd_hit && (cmd_idx == 4'(i))) begin
                led_d[i] = cmd_on;
                tmr_d[i] = (cmd_timed && cmd_on) ? FLASH_LOAD : '0;
            end
        end
    end

    // Synchroniser, debounce, press detection and pending-bit registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            cnt_q      <= '0;
            deb_q      <= '0;
            deb_prev_q <= '0;
            pending_q  <= '0;
        end else begin
            sync1_q    <= buttons;
            sync2_q    <= sync1_q;
            cnt_q      <= cnt_d;
            deb_q      <= deb_d;
            deb_prev_q <= deb_q;
            pending_q  <= pending_d;
        end
    end

    // FIFO pointers, count and overflow flag.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            overflow_q <= overflow_d;
            if (flush) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
                if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
        end
    end

    // FIFO storage. An entry is only read while the count says it is valid, so
    // the storage needs no reset.
    always_ff @(posedge clock) begin
        if (push && !flush) mem_q[wr_ptr_q] <= push_idx;
    end

    // LED drive and flash timers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            led_q <= '0;
            tmr_q <= '0;
        end else begin
            led_q <= led_d;
            tmr_q <= tmr_d;
        end
    end

    assign leds = led_q;

    // Read mux: event word, status word, otherwise zero.
    always_comb begin
        logic [31:0] event_word;
        logic [31:0] status_word;
        event_word     = '0;
        event_word[30] = overflow_q;
        if (!fifo_empty) begin
            event_word[31]  = 1'b1;
            event_word[3:0] = mem_q[rd_ptr_q];
        end
        status_word = {1'b0, overflow_q, 6'b0, 8'(count_q), 16'(deb_q)};
        if (sel_event) begin
            dataOut = event_word;
        end else if (sel_status) begin
            dataOut = status_word;
        end else begin
            dataOut = '0;
        end
    end

endmodule

// File: tb/tb_mmio_button_hub.sv
// Testbench for mmio_button_hub. The reference model treats the event queue as a
// plain queue of indices, treats debouncing as a run of differing synchronised
// samples, and treats each LED as a steady level plus a flash end time measured
// in clock edges.
module tb_mmio_button_hub;

    localparam int N     = 4;
    localparam int D     = 4;
    localparam int DEPTH = 4;
    localparam int F     = 10;
    localparam logic [11:0] A_EVT  = 12'd7;
    localparam logic [11:0] A_STAT = 12'd9;
    localparam logic [11:0] A_LED  = 12'd6;

    logic          clock;
    logic          reset;
    logic [N-1:0]  buttons;
    logic [11:0]   addr;
    logic          wEn;
    logic          rEn;
    logic [31:0]   dataIn;
    logic [31:0]   dataOut;
    logic          hit;
    logic [N-1:0]  leds;

    int tests;
    int fails;

    // Reference model state
    logic [N-1:0] m_s1, m_s2, m_deb, m_deb_prev, m_pend;
    int           m_run[N];
    int           m_fifo[$];
    bit           m_ovf;
    bit           m_led_static[N];
    longint       m_flash_end[N];
    longint       edge_n;

    mmio_button_hub #(
        .NUM_BUTTONS    (N),
        .DEBOUNCE_CYCLES(D),
        .FIFO_DEPTH     (DEPTH),
        .FLASH_CYCLES   (F),
        .ADDR_EVENT     (A_EVT),
        .ADDR_STATUS    (A_STAT),
        .ADDR_LED       (A_LED)
    ) dut (
        .clock  (clock),
        .reset  (reset),
        .buttons(buttons),
        .addr   (addr),
        .wEn    (wEn),
        .rEn    (rEn),
        .dataIn (dataIn),
        .dataOut(dataOut),
        .hit    (hit),
        .leds   (leds)
    );

    // Clock and reset start-up values
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_s1 = '0; m_s2 = '0; m_deb = '0; m_deb_prev = '0; m_pend = '0;
        m_ovf = 1'b0;
        m_fifo.delete();
        for (int i = 0; i < N; i++) begin
            m_run[i] = 0;
            m_led_static[i] = 1'b0;
            m_flash_end[i] = 0;
        end
    endtask

    // One rising edge of the reference model, given the inputs present at that edge.
    task automatic model_edge(input logic [N-1:0] b, input logic [11:0] a, input logic w,
                              input logic r, input logic [31:0] d);
        bit           do_flush, do_pop;
        int           winner, sz, idx;
        logic [N-1:0] rose, new_deb;
        edge_n++;
        do_flush = w && (a == A_STAT) && d[0];
        do_pop   = r && (a == A_EVT) && (m_fifo.size() > 0);
        rose     = m_deb & ~m_deb_prev;
        winner   = -1;
        for (int i = N - 1; i >= 0; i--) if (m_pend[i]) winner = i;
        if (do_flush) begin
            m_fifo.delete();
            m_pend = '0;
            m_ovf  = 1'b0;
        end else begin
            sz = m_fifo.size();
            if (do_pop) void'(m_fifo.pop_front());
            if (winner >= 0) begin
                m_pend[winner] = 1'b0;
                if (sz < DEPTH || do_pop) m_fifo.push_back(winner);
                else m_ovf = 1'b1;
            end
            m_pend = m_pend | rose;
        end
        // A new level is accepted on the (D+1)th consecutive differing synchronised sample.
        new_deb = m_deb;
        for (int i = 0; i < N; i++) begin
            if (m_s2[i] == m_deb[i]) begin
                m_run[i] = 0;
            end else begin
                m_run[i]++;
                if (m_run[i] == D + 1) begin
                    new_deb[i] = m_s2[i];
                    m_run[i] = 0;
                end
            end
        end
        m_deb_prev = m_deb;
        m_deb      = new_deb;
        m_s2       = m_s1;
        m_s1       = b;
        if (w && a == A_LED) begin
            idx = int'(d[3:0]);
            if (idx < N) begin
                if (d[5] && d[4]) begin
                    m_led_static[idx] = 1'b0;
                    m_flash_end[idx]  = edge_n + F;
                end else begin
                    m_led_static[idx] = d[4] && !d[5];
                    m_flash_end[idx]  = 0;
                end
            end
        end
    endtask

    function automatic logic [31:0] exp_leds();
        logic [31:0] v;
        v = '0;
        for (int i = 0; i < N; i++) v[i] = m_led_static[i] || (edge_n < m_flash_end[i]);
        return v;
    endfunction

    function automatic logic [31:0] exp_data(input logic [11:0] a);
        logic [31:0] v;
        v = '0;
        if (a == A_EVT) begin
            v[30] = m_ovf;
            if (m_fifo.size() > 0) begin
                v[31]   = 1'b1;
                v[3:0]  = 4'(m_fifo[0]);
            end
        end else if (a == A_STAT) begin
            v[30]    = m_ovf;
            v[23:16] = 8'(m_fifo.size());
            v[N-1:0] = m_deb;
        end
        return v;
    endfunction

    // Driver: advance one clock, step the model, then compare every output.
    task automatic tick();
        logic [N-1:0] b;
        logic [11:0]  a;
        logic         w, r;
        logic [31:0]  d;
        b = buttons; a = addr; w = wEn; r = rEn; d = dataIn;
        @(posedge clock);
        if (reset) begin
            edge_n++;
            model_reset();
        end else begin
            model_edge(b, a, w, r, d);
        end
        #1;
        check("leds", {28'b0, leds}, exp_leds());
        check("dataOut", dataOut, exp_data(addr));
        check("hit", {31'b0, hit}, {31'b0, (addr == A_EVT) || (addr == A_STAT)});
    endtask

    task automatic idle(input int n);
        wEn = 1'b0;
        rEn = 1'b0;
        repeat (n) tick();
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d);
        addr = a; dataIn = d; wEn = 1'b1; rEn = 1'b0;
        tick();
        wEn = 1'b0;
    endtask

    task automatic pop_ev();
        addr = A_EVT; wEn = 1'b0; rEn = 1'b1;
        tick();
        rEn = 1'b0;
    endtask

    task automatic rd(input logic [11:0] a, output logic [31:0] v);
        addr = a; wEn = 1'b0; rEn = 1'b0;
        #1;
        v = dataOut;
    endtask

    initial begin
        logic [31:0] v;
        int          ones;
        int          bi;
        int          sel;
        tests = 0;
        fails = 0;
        edge_n = 0;
        reset = 1'b1;
        buttons = '0;
        addr = A_EVT;
        wEn = 1'b0;
        rEn = 1'b0;
        dataIn = '0;
        model_reset();

        // Reset values
        #3;
        check("reset_leds", {28'b0, leds}, 32'h0);
        check("reset_event", dataOut, 32'h0);
        check("reset_hit", {31'b0, hit}, 32'h1);
        @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b0;

        // Clean press of button 2: the event appears after edge D+4 = 8
        buttons = 4'b0100;
        addr = A_EVT;
        repeat (8) tick();
        check("press_before_latency", dataOut, 32'h0);
        tick();
        check("press_event", dataOut, 32'h8000_0002);
        rd(A_STAT, v);
        check("press_status", v, 32'h0001_0004);
        pop_ev();
        check("press_popped", dataOut, 32'h0);
        buttons = 4'b0000;
        idle(12);

        // Bounce rejection on button 1, then a steady press
        addr = A_EVT;
        for (int t = 0; t < 10; t++) begin
            buttons[1] = ~buttons[1];
            repeat (2) tick();
        end
        check("bounce_no_event", dataOut, 32'h0);
        buttons[1] = 1'b1;
        repeat (8) tick();
        check("bounce_before_latency", dataOut, 32'h0);
        tick();
        check("bounce_event", dataOut, 32'h8000_0001);
        pop_ev();
        idle(20);
        check("bounce_single_event", dataOut, 32'h0);
        buttons = 4'b0000;
        idle(12);

        // Simultaneous presses of 3, 0 and 1 drain in ascending index order
        buttons = 4'b1011;
        addr = A_EVT;
        idle(14);
        rd(A_EVT, v);
        check("simul_first", v, 32'h8000_0000);
        pop_ev();
        check("simul_second", dataOut, 32'h8000_0001);
        pop_ev();
        check("simul_third", dataOut, 32'h8000_0003);
        pop_ev();
        check("simul_empty", dataOut, 32'h0);
        buttons = 4'b0000;
        idle(12);

        // Overflow: four presses fill the FIFO, the fifth is lost
        buttons = 4'b1111;
        idle(14);
        buttons[0] = 1'b0;
        idle(12);
        buttons[0] = 1'b1;
        idle(12);
        rd(A_STAT, v);
        check("ovf_status", v, 32'h4004_000F);
        wr(A_STAT, 32'h0000_0000);
        rd(A_STAT, v);
        check("ctrl_zero_no_effect", v, 32'h4004_000F);
        wr(A_EVT, 32'hFFFF_FFFF);
        rd(A_EVT, v);
        check("ovf_head_first_press", v, 32'hC000_0000);
        pop_ev();
        check("ovf_after_pop", dataOut, 32'hC000_0001);
        wr(A_STAT, 32'h0000_0001);
        rd(A_STAT, v);
        check("flush_status", v, 32'h0000_000F);
        buttons = 4'b0000;
        idle(12);

        // LED commands: timed flash, on/off, out-of-range index
        wr(A_LED, 32'h32);
        ones = leds[2] ? 1 : 0;
        repeat (14) begin
            tick();
            if (leds[2]) ones++;
        end
        check("flash_length", 32'(ones), 32'd10);
        wr(A_LED, 32'h11);
        check("led1_on", {28'b0, leds}, 32'h2);
        wr(A_LED, 32'h17);
        check("led_index7_ignored", {28'b0, leds}, 32'h2);
        wr(A_LED, 32'h21);
        check("led1_timed_off", {28'b0, leds}, 32'h0);
        wr(A_LED, 32'h11);
        wr(A_LED, 32'h01);
        check("led1_off", {28'b0, leds}, 32'h0);

        // Reset mid-operation: events queued and a flash running
        buttons = 4'b0111;
        idle(14);
        wr(A_LED, 32'h33);
        idle(2);
        check("pre_reset_led", {28'b0, leds}, 32'h8);
        rd(A_STAT, v);
        check("pre_reset_status", v, 32'h0003_0007);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        check("async_reset_leds", {28'b0, leds}, 32'h0);
        addr = A_EVT;
        #1;
        check("async_reset_event", dataOut, 32'h0);
        buttons = 4'b0000;
        tick();
        tick();
        reset = 1'b0;
        idle(3);
        rd(A_STAT, v);
        check("post_reset_status", v, 32'h0);

        // Randomised traffic against the reference model
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 7) == 0) begin
                bi = $urandom_range(0, N - 1);
                buttons[bi] = ~buttons[bi];
            end
            sel = $urandom_range(0, 7);
            if (sel <= 3)      addr = A_EVT;
            else if (sel <= 5) addr = A_STAT;
            else if (sel == 6) addr = A_LED;
            else               addr = 12'($urandom_range(0, 4095));
            rEn = ($urandom_range(0, 2) == 0);
            wEn = ($urandom_range(0, 5) == 0);
            dataIn = $urandom;
            if (addr == A_STAT) dataIn[0] = ($urandom_range(0, 9) == 0);
            if (addr == A_LED)  dataIn = 32'($urandom_range(0, 63)) & 32'h0000_0037;
            tick();
        end
        idle(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
